// File: rtl/inst_fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
// req/addr go out with the request; ready, rvalid and rdata come back.
interface inst_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: PC register, variable-latency imem handshake,
// one-at-a-time presentation to decode with branch/jump redirect on ack.
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned CNT_W    = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    inst_fetch_unit_if.master     imem,
    output logic                  inst_valid,
    output logic [31:0]           inst,
    output logic [5:0]            opcode,
    output logic [5:0]            funct,
    output logic [31:0]           pc,
    output logic [31:0]           pc_plus4,
    input  logic                  inst_ack,
    input  logic                  branch,
    input  logic                  jump,
    input  logic                  alu_zero,
    output logic [CNT_W-1:0]      inst_count
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc_nxt;
    logic [31:0] br_off;
    logic [31:0] jmp_tgt;

    assign opcode         = inst[31:26];
    assign funct          = inst[5:0];
    assign pc_plus4       = pc + 32'd4;
    assign imem.imem_addr = {pc[31:2], 2'b00};

    assign br_off  = {{14{inst[15]}}, inst[15:0], 2'b00};
    assign jmp_tgt = {pc_plus4[31:28], inst[25:0], 2'b00};

    // Jump takes priority over a taken branch.
    always_comb begin
        pc_nxt = pc_plus4;
        if (jump) begin
            pc_nxt = jmp_tgt;
        end else if (branch && alu_zero) begin
            pc_nxt = pc_plus4 + br_off;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        imem.imem_req = 1'b0;
        inst_valid    = 1'b0;
        case (state)
            IDLE: state_nxt = REQ;
            REQ: begin
                imem.imem_req = 1'b1;
                if (imem.imem_ready) state_nxt = WAIT;
            end
            WAIT: begin
                if (imem.imem_rvalid) state_nxt = HOLD;
            end
            HOLD: begin
                inst_valid = 1'b1;
                if (inst_ack) state_nxt = REQ;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc         <= RESET_PC;
            inst       <= '0;
            inst_count <= '0;
        end else begin
            if (state == WAIT && imem.imem_rvalid) begin
                inst <= imem.imem_rdata;
            end
            if (state == HOLD && inst_ack) begin
                pc         <= pc_nxt;
                inst_count <= inst_count + CNT_W'(1);
            end
        end
    end

endmodule
